// File: rtl/smss_pkg.sv
// smss_pkg: shared definitions for the GF(2^6) power-map S-box pipeline.
//   Field: GF(2^6) in polynomial basis, modulus x^6 + x + 1.
//   Composite: GF((2^3)^2) as {a1, a0} = a1*Y + a0 with Y^2 = Y + 1,
//   subfield GF(2^3) modulo z^3 + z + 1.
//   ISO maps polynomial basis -> composite; ISO_INV maps back. Both matrices
//   are derived at elaboration from a root of x^6 + x + 1 in the composite
//   field, so they always match the arithmetic defined below.
package smss_pkg;

  localparam int FIELD_W = 6;
  localparam int SUB_W   = 3;

  typedef enum logic [1:0] {
    MODE_P5  = 2'd0,  // x^5
    MODE_P38 = 2'd1,  // x^38, inverse permutation of x^5
    MODE_INV = 2'd2,  // x^62, inversion with 0 -> 0
    MODE_BYP = 2'd3   // y = x
  } smss_mode_e;

  // Entry [j] is the image of input basis bit j.
  typedef logic [FIELD_W-1:0][FIELD_W-1:0] mat6_t;

  function automatic logic [SUB_W-1:0] gf8_mul(input logic [SUB_W-1:0] a,
                                               input logic [SUB_W-1:0] b);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < SUB_W; i++)
      if (b[i]) p = p ^ (5'(a) << i);
    if (p[4]) p = p ^ 5'b10110;  // z * (z^3 + z + 1)
    if (p[3]) p = p ^ 5'b01011;  // z^3 + z + 1
    return p[2:0];
  endfunction

  // Squaring in GF(2^3) is linear: z^4 folds to z^2 + z.
  function automatic logic [SUB_W-1:0] gf8_sq(input logic [SUB_W-1:0] a);
    return {a[1] ^ a[2], a[2], a[0]};
  endfunction

  // a^-1 = a^6 in GF(2^3); 0 maps to 0.
  function automatic logic [SUB_W-1:0] gf8_inv(input logic [SUB_W-1:0] a);
    return gf8_mul(gf8_sq(gf8_sq(a)), gf8_sq(a));
  endfunction

  function automatic logic [FIELD_W-1:0] gfc_mul(input logic [FIELD_W-1:0] a,
                                                 input logic [FIELD_W-1:0] b);
    logic [SUB_W-1:0] hh;
    hh = gf8_mul(a[5:3], b[5:3]);
    return {hh ^ gf8_mul(a[5:3], b[2:0]) ^ gf8_mul(a[2:0], b[5:3]),
            hh ^ gf8_mul(a[2:0], b[2:0])};
  endfunction

  // (a1 Y + a0)^2 = a1^2 Y + (a1^2 + a0^2)
  function automatic logic [FIELD_W-1:0] gfc_sq(input logic [FIELD_W-1:0] a);
    logic [SUB_W-1:0] h;
    h = gf8_sq(a[5:3]);
    return {h, h ^ gf8_sq(a[2:0])};
  endfunction

  function automatic logic [FIELD_W-1:0] iso_apply(input mat6_t m,
                                                   input logic [FIELD_W-1:0] x);
    logic [FIELD_W-1:0] r;
    r = '0;
    for (int j = 0; j < FIELD_W; j++)
      if (x[j]) r = r ^ m[j];
    return r;
  endfunction

  // Columns are g^j for the first composite g with g^6 + g + 1 = 0.
  function automatic mat6_t build_iso();
    mat6_t            m;
    logic [FIELD_W-1:0] g, c;
    logic             found;
    g     = '0;
    found = 1'b0;
    for (int k = 2; k < 64; k++) begin
      c = 6'(k);
      if (!found && ((gfc_mul(gfc_sq(gfc_sq(c)), gfc_sq(c)) ^ c ^ 6'h01) == 6'h00)) begin
        g     = c;
        found = 1'b1;
      end
    end
    m[0] = 6'h01;
    for (int j = 1; j < FIELD_W; j++) m[j] = gfc_mul(m[j-1], g);
    return m;
  endfunction

  function automatic mat6_t build_iso_inv(input mat6_t m);
    mat6_t r;
    r = '0;
    for (int x = 0; x < 64; x++)
      for (int k = 0; k < FIELD_W; k++)
        if (iso_apply(m, 6'(x)) == (6'h01 << k)) r[k] = 6'(x);
    return r;
  endfunction

  localparam mat6_t ISO     = build_iso();
  localparam mat6_t ISO_INV = build_iso_inv(ISO);

endpackage

// File: rtl/smss_gf64_power_lane.sv
// smss_gf64_power_lane: one combinational S-box lane.
//   Every mode is reduced to a single composite product y = p * q, so the
//   lane splits cleanly into a pre half (basis map, squarings, first
//   multiply / norm inversion) and a post half (final multiply, inverse map,
//   lane mask). The caller may register p/q between the halves.
//   Pre:  i_x, i_mode -> o_p, o_q   (composite basis)
//   Post: i_p, i_q, i_en -> o_y     (polynomial basis, 0 when disabled)
module smss_gf64_power_lane
  import smss_pkg::*;
(
  input  logic [FIELD_W-1:0] i_x,
  input  smss_mode_e         i_mode,
  output logic [FIELD_W-1:0] o_p,
  output logic [FIELD_W-1:0] o_q,
  input  logic [FIELD_W-1:0] i_p,
  input  logic [FIELD_W-1:0] i_q,
  input  logic               i_en,
  output logic [FIELD_W-1:0] o_y
);

  logic [FIELD_W-1:0] w_xc, w_x2, w_x4, w_x32;
  logic [SUB_W-1:0]   w_norm, w_ninv;

  assign w_xc  = iso_apply(ISO, i_x);
  assign w_x2  = gfc_sq(w_xc);
  assign w_x4  = gfc_sq(w_x2);
  assign w_x32 = gfc_sq(gfc_sq(gfc_sq(w_x4)));

  // Norm of a1 Y + a0 over GF(2^3); its conjugate is a1 Y + (a1 + a0).
  assign w_norm = gf8_sq(w_xc[5:3]) ^ gf8_mul(w_xc[5:3], w_xc[2:0]) ^ gf8_sq(w_xc[2:0]);
  assign w_ninv = gf8_inv(w_norm);

  always_comb begin
    o_p = 6'h01;
    o_q = w_xc;
    case (i_mode)
      MODE_P5:  begin o_p = w_x4;                 o_q = w_xc;  end
      MODE_P38: begin o_p = gfc_mul(w_x2, w_x4);  o_q = w_x32; end
      MODE_INV: begin
        o_p = {3'b000, w_ninv};
        o_q = {w_xc[5:3], w_xc[5:3] ^ w_xc[2:0]};
      end
      default: ;
    endcase
  end

  assign o_y = i_en ? iso_apply(ISO_INV, gfc_mul(i_p, i_q)) : '0;

endmodule

// File: rtl/smss_power_pipe.sv
// smss_power_pipe: NUM_LANES-wide pipelined GF(2^6) power S-box.
//   clk, rst (sync, active high)
//   in_valid/in_ready, in_mode, in_lane_en, in_data : input stream
//   out_valid/out_ready, out_mode, out_data         : output stream
//   Optional macro SMSS_PARITY_EN adds in_parity, out_parity, par_err.
//   Whole pipe advances when en = !out_valid || out_ready; in_ready = en.
//   With PIPE_STAGES > 1, stage 1 holds the lane p/q operands and later
//   stages hold finished results; with PIPE_STAGES = 1 the lane is fully
//   combinational ahead of the only register.
module smss_power_pipe
  import smss_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_mode,
  input  logic [NUM_LANES-1:0]         in_lane_en,
  input  logic [FIELD_W*NUM_LANES-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_mode,
  output logic [FIELD_W*NUM_LANES-1:0] out_data
`ifdef SMSS_PARITY_EN
  ,
  input  logic [NUM_LANES-1:0]         in_parity,
  output logic [NUM_LANES-1:0]         out_parity,
  output logic                         par_err
`endif
);

  if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
    $fatal(1, "smss_power_pipe: NUM_LANES must be 1..16");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $fatal(1, "smss_power_pipe: PIPE_STAGES must be 1..4");
  end

  logic                                w_en;
  logic [PIPE_STAGES:1]                r_vld_pipe;
  smss_mode_e                          r_mode [PIPE_STAGES:1];
  logic [NUM_LANES-1:0][FIELD_W-1:0]   w_pre_p, w_pre_q, w_post_p, w_post_q, w_y, w_out_y;
  logic [NUM_LANES-1:0]                w_post_en;

  assign out_valid = r_vld_pipe[PIPE_STAGES];
  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_mode  = r_mode[PIPE_STAGES];
  assign out_data  = w_out_y;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    smss_gf64_power_lane u_lane (
      .i_x    (in_data[FIELD_W*l +: FIELD_W]),
      .i_mode (smss_mode_e'(in_mode)),
      .o_p    (w_pre_p[l]),
      .o_q    (w_pre_q[l]),
      .i_p    (w_post_p[l]),
      .i_q    (w_post_q[l]),
      .i_en   (w_post_en[l]),
      .o_y    (w_y[l])
    );
  end

  // Valid and mode shift together; bubbles travel as zeros in r_vld_pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int s = 1; s <= PIPE_STAGES; s++) r_mode[s] <= MODE_P5;
    end else if (w_en) begin
      r_vld_pipe[1] <= in_valid;
      r_mode[1]     <= smss_mode_e'(in_mode);
      for (int s = 2; s <= PIPE_STAGES; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_mode[s]     <= r_mode[s-1];
      end
    end
  end

`ifdef SMSS_PARITY_EN
  logic [NUM_LANES-1:0] w_in_par_bad, w_y_par;
  logic                 r_par_err;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_par
    assign w_in_par_bad[l] = in_parity[l] ^ (^in_data[FIELD_W*l +: FIELD_W]);
    assign w_y_par[l]      = ^w_y[l];
  end

  always_ff @(posedge clk) begin
    if (rst)                                       r_par_err <= 1'b0;
    else if (in_valid && w_en && (|w_in_par_bad))  r_par_err <= 1'b1;
  end
  assign par_err = r_par_err;
`endif

  if (PIPE_STAGES == 1) begin : g_one
    logic [NUM_LANES-1:0][FIELD_W-1:0] r_y;
    assign w_post_p  = w_pre_p;
    assign w_post_q  = w_pre_q;
    assign w_post_en = in_lane_en;
    always_ff @(posedge clk) begin
      if (rst)       r_y <= '0;
      else if (w_en) r_y <= w_y;
    end
    assign w_out_y = r_y;
`ifdef SMSS_PARITY_EN
    logic [NUM_LANES-1:0] r_ypar;
    always_ff @(posedge clk) begin
      if (rst)       r_ypar <= '0;
      else if (w_en) r_ypar <= w_y_par;
    end
    assign out_parity = r_ypar;
`endif
  end else begin : g_multi
    logic [NUM_LANES-1:0][FIELD_W-1:0] r_p, r_q;
    logic [NUM_LANES-1:0]              r_len;
    logic [NUM_LANES-1:0][FIELD_W-1:0] r_y [PIPE_STAGES:2];
    assign w_post_p  = r_p;
    assign w_post_q  = r_q;
    assign w_post_en = r_len;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_p   <= '0;
        r_q   <= '0;
        r_len <= '0;
        for (int s = 2; s <= PIPE_STAGES; s++) r_y[s] <= '0;
      end else if (w_en) begin
        r_p    <= w_pre_p;
        r_q    <= w_pre_q;
        r_len  <= in_lane_en;
        r_y[2] <= w_y;
        for (int s = 3; s <= PIPE_STAGES; s++) r_y[s] <= r_y[s-1];
      end
    end
    assign w_out_y = r_y[PIPE_STAGES];
`ifdef SMSS_PARITY_EN
    logic [NUM_LANES-1:0] r_ypar [PIPE_STAGES:2];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 2; s <= PIPE_STAGES; s++) r_ypar[s] <= '0;
      end else if (w_en) begin
        r_ypar[2] <= w_y_par;
        for (int s = 3; s <= PIPE_STAGES; s++) r_ypar[s] <= r_ypar[s-1];
      end
    end
    assign out_parity = r_ypar[PIPE_STAGES];
`endif
  end

endmodule
